// File: rtl/tsc_readout_ctrl_if.sv
// Cache-side req/rdy handshake and framed output byte stream of the readout controller.
// master = controller side, slave = cache plus downstream consumer.
interface tsc_readout_ctrl_if;
    logic        tsc_start;
    logic        tsc_trd;
    logic [31:0] tsc_trigtm;
    logic        tsc_req;
    logic        tsc_rdy;
    logic [7:0]  tsc_dat;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport master (
        output tsc_start, tsc_req, out_valid, out_data, out_last,
        input  tsc_trd, tsc_trigtm, tsc_rdy, tsc_dat, out_ready
    );

    modport slave (
        input  tsc_start, tsc_req, out_valid, out_data, out_last,
        output tsc_trd, tsc_trigtm, tsc_rdy, tsc_dat, out_ready
    );
endinterface

// File: rtl/tsc_readout_ctrl.sv
// Purpose: arm the trigger surround cache, latch the trigger time, stream 4 ts bytes + BUF_LEN samples.
// Latency: >=3 cycles per sample byte (REQ, WAIT_RDY, EMIT); header bytes one per accepted beat.
// Backpressure: out_valid/out_data/out_last hold until out_ready; abort drops them immediately.
module tsc_readout_ctrl #(
    parameter int BUF_LEN     = 32,
    parameter int RETRIG_GAP  = 16,
    parameter int REQ_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                continuous,
    input  logic                abort,
    tsc_readout_ctrl_if.master  bus,
    output logic                busy,
    output logic                err,
    output logic [15:0]         frame_cnt,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ARM       = 4'd1,
        S_WAIT_TRIG = 4'd2,
        S_HDR       = 4'd3,
        S_REQ       = 4'd4,
        S_WAIT_RDY  = 4'd5,
        S_EMIT      = 4'd6,
        S_DONE      = 4'd7,
        S_GAP       = 4'd8,
        S_ERR       = 4'd9
    } state_t;

    localparam int SW = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
    localparam int TW = $clog2(REQ_TIMEOUT + 1);
    localparam int GW = $clog2(RETRIG_GAP + 1);
    localparam logic [SW-1:0] LAST_IDX = SW'(BUF_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(REQ_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(RETRIG_GAP - 1);

    state_t         state_q, state_d;
    logic [31:0]    ts_q;
    logic [1:0]     hdr_idx;
    logic [SW-1:0]  sample_cnt;
    logic [TW-1:0]  to_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [7:0]     data_q;
    logic           err_q;
    logic [15:0]    frame_q;

    logic           ov, start, req, hs, is_last;
    logic [7:0]     hdr_next;

    assign is_last = (sample_cnt == LAST_IDX);
    assign hs      = ov & bus.out_ready;

    // Byte presented after the header beat at hdr_idx is accepted.
    always_comb begin
        hdr_next = ts_q[31:24];
        case (hdr_idx)
            2'd0:    hdr_next = ts_q[23:16];
            2'd1:    hdr_next = ts_q[15:8];
            2'd2:    hdr_next = ts_q[7:0];
            default: hdr_next = ts_q[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ov      = 1'b0;
        start   = 1'b0;
        req     = 1'b0;
        case (state_q)
            S_IDLE:      if (go) state_d = S_ARM;
            S_ARM: begin
                start   = 1'b1;
                state_d = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: if (bus.tsc_trd) state_d = S_HDR;
            S_HDR: begin
                ov = 1'b1;
                if (bus.out_ready && hdr_idx == 2'd3) state_d = S_REQ;
            end
            S_REQ: begin
                req     = 1'b1;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (bus.tsc_rdy)             state_d = S_EMIT;
                else if (to_cnt == TO_LAST)  state_d = S_ERR;
            end
            S_EMIT: begin
                ov = 1'b1;
                if (bus.out_ready) state_d = is_last ? S_DONE : S_REQ;
            end
            S_DONE:      state_d = continuous ? S_GAP : S_IDLE;
            S_GAP:       if (gap_cnt == GAP_LAST) state_d = S_ARM;
            S_ERR:       if (go) state_d = S_ARM;
            default:     state_d = S_IDLE;
        endcase
        // Abort outranks everything, including a same-cycle handshake or cache strobe.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            ov      = 1'b0;
            start   = 1'b0;
            req     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q       <= '0;
            hdr_idx    <= '0;
            sample_cnt <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            frame_q    <= '0;
        end else begin
            case (state_q)
                S_WAIT_TRIG: if (bus.tsc_trd) begin
                    ts_q    <= bus.tsc_trigtm;
                    data_q  <= bus.tsc_trigtm[31:24];
                    hdr_idx <= 2'd0;
                end
                S_HDR: if (hs) begin
                    hdr_idx    <= hdr_idx + 2'd1;
                    data_q     <= hdr_next;
                    sample_cnt <= '0;
                end
                S_REQ:       to_cnt <= '0;
                S_WAIT_RDY: begin
                    if (bus.tsc_rdy) data_q <= bus.tsc_dat;
                    else             to_cnt <= to_cnt + TW'(1);
                end
                S_EMIT:      if (hs && !is_last) sample_cnt <= sample_cnt + SW'(1);
                S_DONE: begin
                    gap_cnt <= '0;
                    if (!abort) frame_q <= frame_q + 16'd1;
                end
                S_GAP:       gap_cnt <= gap_cnt + GW'(1);
                default: ;
            endcase
            // Set on entry to ERR, cleared when go or abort leaves it.
            err_q <= (state_d == S_ERR);
        end
    end

    assign bus.tsc_start = start;
    assign bus.tsc_req   = req;
    assign bus.out_valid = ov;
    assign bus.out_data  = data_q;
    assign bus.out_last  = ov & is_last & (state_q == S_EMIT);

    assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
    assign err       = err_q;
    assign frame_cnt = frame_q;
    assign state     = state_q;

endmodule
